// File: rtl/fanin_pkg.sv
// Shared types and default sizing for the child fan-in arbiter and its output FIFO.
package fanin_pkg;

   localparam int NUM_CHILD_DEF = 5;
   localparam int DATA_W_DEF    = 16;
   localparam int ID_W_DEF      = 3;

   typedef enum logic {
      IDLE,
      LOCKED
   } arb_state_e;

   typedef struct packed {
      logic [ID_W_DEF-1:0]   id;
      logic                  last;
      logic [DATA_W_DEF-1:0] data;
   } fanin_beat_t;

endpackage

// File: rtl/fanin_skid_fifo.sv
// Two-entry FIFO of beats; full is registered state, so upstream ready never sees the downstream ready.
module fanin_skid_fifo
   import fanin_pkg::*;
#(
   parameter type beat_t = fanin_beat_t
)(
   input  logic  clk,
   input  logic  rst,
   input  logic  push,
   input  beat_t push_beat,
   input  logic  pop,
   output beat_t head,
   output logic  full,
   output logic  empty
);

   beat_t      mem [2];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] count;

   assign full  = (count == 2'd2);
   assign empty = (count == 2'd0);
   assign head  = mem[rd_ptr];

   // Storage is cleared on reset so the head reads as all-zero while empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_beat;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   assert property (@(posedge clk) disable iff (rst) push |-> !full);
   assert property (@(posedge clk) disable iff (rst) pop |-> !empty);

endmodule

// File: rtl/child_fanin_arbiter.sv
// Round-robin, packet-locked fan-in of NUM_CHILD child streams onto one upstream channel.
module child_fanin_arbiter
   import fanin_pkg::*;
#(
   parameter int NUM_CHILD = NUM_CHILD_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int ID_W      = ID_W_DEF
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CHILD-1:0]        child_valid,
   output logic [NUM_CHILD-1:0]        child_ready,
   input  logic [NUM_CHILD*DATA_W-1:0] child_data,
   input  logic [NUM_CHILD-1:0]        child_last,
   output logic                        parent_valid,
   input  logic                        parent_ready,
   output logic [DATA_W-1:0]           parent_data,
   output logic [ID_W-1:0]             parent_id,
   output logic                        parent_last,
   output logic                        busy
);

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic              last;
      logic [DATA_W-1:0] data;
   } beat_t;

   arb_state_e      state;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] gnt;
   logic [ID_W-1:0] sel;
   logic [ID_W-1:0] cur;
   logic            any_valid;
   logic            fifo_full;
   logic            fifo_empty;
   logic            push;
   logic            pop;
   beat_t           push_beat;
   beat_t           head;

   // Scan starts one past the last packet owner, so the owner drops to lowest priority.
   always_comb begin
      sel       = '0;
      any_valid = 1'b0;
      for (int k = 1; k <= NUM_CHILD; k++) begin
         if (!any_valid && child_valid[(int'(rr_ptr) + k) % NUM_CHILD]) begin
            any_valid = 1'b1;
            sel       = ID_W'((int'(rr_ptr) + k) % NUM_CHILD);
         end
      end
   end

   assign cur = (state == LOCKED) ? gnt : sel;

   always_comb begin
      child_ready = '0;
      if (!fifo_full) begin
         if (state == LOCKED) begin
            child_ready[gnt] = 1'b1;
         end else if (any_valid) begin
            child_ready[sel] = 1'b1;
         end
      end
   end

   always_comb begin
      push_beat      = '0;
      push_beat.id   = cur;
      push_beat.last = child_last[cur];
      push_beat.data = child_data[cur*DATA_W +: DATA_W];
   end

   assign push = |(child_valid & child_ready);
   assign pop  = parent_valid & parent_ready;

   // The lock holds from a non-last beat until the same child delivers its last beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         rr_ptr <= ID_W'(NUM_CHILD - 1);
         gnt    <= '0;
      end else if (push) begin
         case (state)
            IDLE: begin
               if (push_beat.last) begin
                  rr_ptr <= sel;
               end else begin
                  state <= LOCKED;
                  gnt   <= sel;
               end
            end
            LOCKED: begin
               if (push_beat.last) begin
                  state  <= IDLE;
                  rr_ptr <= gnt;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   fanin_skid_fifo #(
      .beat_t(beat_t)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_beat (push_beat),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign parent_valid = !fifo_empty;
   assign parent_data  = head.data;
   assign parent_id    = head.id;
   assign parent_last  = head.last;
   assign busy         = (state == LOCKED);

   assert property (@(posedge clk) disable iff (rst) $onehot0(child_ready));

endmodule

// File: tb/tb_child_fanin_arbiter.sv
// Randomized and directed bench for child_fanin_arbiter against a queue-based reference model.
module tb_child_fanin_arbiter;

   localparam int N  = 5;
   localparam int DW = 16;
   localparam int IW = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    child_valid = '0;
   logic [N-1:0]    child_ready;
   logic [N*DW-1:0] child_data = '0;
   logic [N-1:0]    child_last = '0;
   logic            parent_valid;
   logic            parent_ready = 1'b0;
   logic [DW-1:0]   parent_data;
   logic [IW-1:0]   parent_id;
   logic            parent_last;
   logic            busy;

   always #5 clk = ~clk;

   child_fanin_arbiter #(.NUM_CHILD(N), .DATA_W(DW), .ID_W(IW)) dut (
      .clk          (clk),
      .rst          (rst),
      .child_valid  (child_valid),
      .child_ready  (child_ready),
      .child_data   (child_data),
      .child_last   (child_last),
      .parent_valid (parent_valid),
      .parent_ready (parent_ready),
      .parent_data  (parent_data),
      .parent_id    (parent_id),
      .parent_last  (parent_last),
      .busy         (busy)
   );

   typedef struct {
      int           id;
      bit           last;
      logic [DW-1:0] data;
   } mbeat_t;

   // Reference model: buffered beats, current packet owner (-1 = none), last packet owner.
   mbeat_t q[$];
   int     locked   = -1;
   int     last_win = N - 1;

   int     checks = 0;
   int     errors = 0;
   bit [N-1:0] acc = '0;
   bit     seq_mode = 0;
   int     out_seq[N];
   int     out_open = -1;
   int     out_ids[$];
   logic [DW-1:0] out_data[$];
   int     pk_left[N];
   int     gen_seq[N];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic logic [N-1:0] modelReady();
      logic [N-1:0] r;
      bit found;
      int i;
      r = '0;
      found = 0;
      if (q.size() < 2) begin
         if (locked >= 0) begin
            r[locked] = 1'b1;
         end else begin
            for (int k = 1; k <= N; k++) begin
               i = (last_win + k) % N;
               if (!found && child_valid[i]) begin
                  found = 1;
                  r[i] = 1'b1;
               end
            end
         end
      end
      return r;
   endfunction

   // One clock: compare DUT against the model, then advance the model across the rising edge.
   task automatic stepCycle();
      logic [N-1:0] exp_ready;
      bit popped;
      int win;
      mbeat_t nb;
      int id;
      #1;
      exp_ready = modelReady();
      checkOutput("child_ready", child_ready, exp_ready);
      checkOutput("parent_valid", parent_valid, 32'(q.size() != 0));
      if (q.size() != 0) begin
         checkOutput("parent_data", parent_data, q[0].data);
         checkOutput("parent_id", parent_id, q[0].id);
         checkOutput("parent_last", parent_last, q[0].last);
      end
      checkOutput("busy", busy, 32'(locked >= 0));
      acc = exp_ready & child_valid;
      popped = (q.size() != 0) && parent_ready;
      win = -1;
      for (int i = 0; i < N; i++) if (acc[i]) win = i;
      if (win >= 0) begin
         nb.id   = win;
         nb.last = child_last[win];
         nb.data = child_data[win*DW +: DW];
      end
      if (popped) begin
         out_ids.push_back(q[0].id);
         out_data.push_back(q[0].data);
         if (seq_mode) begin
            id = int'(parent_id);
            checkOutput("src_tag", 32'(parent_data[15:13]), 32'(parent_id));
            if (id < N) begin
               checkOutput("seq_order", 32'(parent_data[12:0]), 32'(out_seq[id] % 8192));
               out_seq[id]++;
            end
            if (out_open >= 0) checkOutput("no_interleave", id, out_open);
            out_open = parent_last ? -1 : id;
         end
      end
      @(posedge clk);
      if (popped) void'(q.pop_front());
      if (win >= 0) begin
         q.push_back(nb);
         if (nb.last) begin
            locked   = -1;
            last_win = win;
         end else begin
            locked = win;
         end
      end
      @(negedge clk);
   endtask

   // Asynchronous reset: outputs must clear before any clock edge occurs.
   task automatic resetDut();
      rst = 1'b1;
      child_valid  = '0;
      child_last   = '0;
      child_data   = '0;
      parent_ready = 1'b0;
      #1;
      checkOutput("rst_parent_valid", parent_valid, 0);
      checkOutput("rst_parent_data", parent_data, 0);
      checkOutput("rst_parent_id", parent_id, 0);
      checkOutput("rst_parent_last", parent_last, 0);
      checkOutput("rst_child_ready", child_ready, 0);
      checkOutput("rst_busy", busy, 0);
      q.delete();
      locked   = -1;
      last_win = N - 1;
      acc      = '0;
      out_open = -1;
      out_ids.delete();
      out_data.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic applyStimulus();
      for (int i = 0; i < N; i++) begin
         if (acc[i]) begin
            child_valid[i] = 1'b0;
            gen_seq[i]++;
            pk_left[i]--;
         end
         if (!child_valid[i] && $urandom_range(0, 99) < 50) begin
            if (pk_left[i] == 0) pk_left[i] = $urandom_range(1, 4);
            child_valid[i] = 1'b1;
            child_last[i]  = (pk_left[i] == 1);
            child_data[i*DW +: DW] = {3'(i), 13'(gen_seq[i])};
         end
      end
      parent_ready = ($urandom_range(0, 99) < 70);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n_acc;
      int beat;
      int exp_ids[6];

      // Single beat from child 2, same-cycle grant, one-cycle latency to the output.
      resetDut();
      child_valid[2] = 1'b1;
      child_data[2*DW +: DW] = 16'hABCD;
      child_last[2] = 1'b1;
      parent_ready = 1'b1;
      #1;
      checkOutput("t1_grant", child_ready, 5'b00100);
      stepCycle();
      child_valid = '0;
      #1;
      checkOutput("t1_valid", parent_valid, 1);
      checkOutput("t1_data", parent_data, 16'hABCD);
      checkOutput("t1_id", parent_id, 2);
      checkOutput("t1_last", parent_last, 1);
      stepCycle();

      // All children valid with single-beat packets: strict rotation at full rate.
      resetDut();
      exp_ids = '{0, 1, 2, 3, 4, 0};
      for (int i = 0; i < N; i++) child_data[i*DW +: DW] = 16'h1000 + 16'(i);
      child_last   = '1;
      child_valid  = '1;
      parent_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         stepCycle();
         #1;
         checkOutput("t2_valid", parent_valid, 1);
         checkOutput("t2_id", parent_id, exp_ids[c]);
         checkOutput("t2_data", parent_data, 16'h1000 + 16'(exp_ids[c]));
      end
      child_valid = '0;
      stepCycle();

      // Child 1 locks a 4-beat packet; child 0 waits until the lock drops.
      resetDut();
      parent_ready = 1'b1;
      beat = 0;
      child_valid[1] = 1'b1;
      child_data[1*DW +: DW] = 16'h2000;
      child_last[1] = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (beat >= 1 && beat <= 3) begin
            #1;
            checkOutput("t3_busy", busy, 1);
            checkOutput("t3_ready0", child_ready[0], 0);
         end
         stepCycle();
         if (c == 0) begin
            child_valid[0] = 1'b1;
            child_data[0 +: DW] = 16'h3000;
            child_last[0] = 1'b1;
         end
         if (acc[0]) child_valid[0] = 1'b0;
         if (acc[1]) begin
            beat++;
            if (beat == 4) child_valid[1] = 1'b0;
            child_data[1*DW +: DW] = 16'h2000 + 16'(beat);
            child_last[1] = (beat == 3);
         end
      end
      checkOutput("t3_count", out_ids.size(), 5);
      if (out_ids.size() == 5) begin
         for (int i = 0; i < 4; i++) checkOutput("t3_lock_id", out_ids[i], 1);
         checkOutput("t3_after_id", out_ids[4], 0);
      end

      // Backpressure: only two beats fit, then everything holds until parent_ready returns.
      resetDut();
      beat = 0;
      n_acc = 0;
      child_valid[3] = 1'b1;
      child_data[3*DW +: DW] = 16'h4000;
      child_last[3] = 1'b0;
      for (int c = 0; c < 18; c++) begin
         if (c == 6) begin
            checkOutput("t4_accepted", n_acc, 2);
            #1;
            checkOutput("t4_ready_low", child_ready, 0);
            checkOutput("t4_held", parent_data, 16'h4000);
            parent_ready = 1'b1;
         end
         stepCycle();
         if (acc[3]) begin
            n_acc++;
            beat++;
            if (beat == 6) child_valid[3] = 1'b0;
            child_data[3*DW +: DW] = 16'h4000 + 16'(beat);
            child_last[3] = (beat == 5);
         end
      end
      checkOutput("t4_drained", out_data.size(), 6);
      if (out_data.size() == 6) begin
         for (int i = 0; i < 6; i++) checkOutput("t4_order", out_data[i], 16'h4000 + 16'(i));
      end

      // Reset mid-packet from child 4, then child 0 wins over child 4.
      resetDut();
      beat = 0;
      child_valid[4] = 1'b1;
      child_data[4*DW +: DW] = 16'h5000;
      child_last[4] = 1'b0;
      for (int c = 0; c < 10 && beat < 2; c++) begin
         stepCycle();
         if (acc[4]) begin
            beat++;
            child_data[4*DW +: DW] = 16'h5000 + 16'(beat);
         end
      end
      checkOutput("t5_beats_before_rst", beat, 2);
      resetDut();
      child_valid  = 5'b10001;
      child_last   = 5'b10001;
      child_data[0 +: DW]    = 16'h6000;
      child_data[4*DW +: DW] = 16'h6004;
      parent_ready = 1'b1;
      #1;
      checkOutput("t5_first_grant", child_ready, 5'b00001);
      stepCycle();
      if (acc[0]) child_valid[0] = 1'b0;
      stepCycle();
      child_valid = '0;
      stepCycle();
      stepCycle();

      // Random traffic against the model, with per-child ordering and no interleaving.
      resetDut();
      seq_mode = 1;
      for (int i = 0; i < N; i++) begin
         out_seq[i] = 0;
         gen_seq[i] = 0;
         pk_left[i] = 0;
      end
      for (int c = 0; c < 10000; c++) begin
         applyStimulus();
         stepCycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/child_fanin_arbiter.md
Name: child_fanin_arbiter

Overview:
Fan-in counterpart to the hierarchy's root-to-child fan-out: a parent node collects packet streams from its NUM_CHILD child instances (inst_0..inst_4) onto one upstream channel. Arbitration is round-robin and packet-locked: a granted child keeps the channel until its last beat. Output is buffered by a 2-entry skid FIFO, so no combinational path runs from parent_ready to child_ready.

Parameters:
NUM_CHILD, 5, number of child channels (2..8)
DATA_W, 16, payload width per beat
ID_W, 3, width of source index; must satisfy 2**ID_W >= NUM_CHILD

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
child_valid  input  NUM_CHILD  per-child beat valid
child_ready  output  NUM_CHILD  per-child beat accept
child_data  input  NUM_CHILD*DATA_W  child i data at bits [i*DATA_W +: DATA_W]
child_last  input  NUM_CHILD  per-child end-of-packet marker
parent_valid  output  1  upstream beat valid
parent_ready  input  1  upstream accept
parent_data  output  DATA_W  upstream payload
parent_id  output  ID_W  index of the source child of the current beat
parent_last  output  1  end-of-packet marker
busy  output  1  high while a packet is locked (LOCKED state)

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=NUM_CHILD-1 (child 0 has first priority), FIFO empty (count=0). parent_valid=0, parent_data=0, parent_id=0, parent_last=0, child_ready=0, busy=0.
- Reset mid-packet: buffered beats are discarded and the lock is dropped. Children must restart their packets.
- Transfer rule: a beat transfers on any channel when valid & ready are both high at a clock edge. A valid signal, once raised, stays high with data stable until the transfer.
- fifo_full = (count==2). A child_ready bit can be high only when !fifo_full, and at most one bit is high at a time.
- IDLE:
  - sel = first i with child_valid[i], scanning (rr_ptr+1) mod N, then upward with wrap-around.
  - child_ready[sel]=1 when any child is valid and !fifo_full. Grant is combinational, so the first beat can transfer in the same cycle.
  - Transfer with last=1: stay IDLE, rr_ptr<=sel.
  - Transfer with last=0: go to LOCKED, gnt<=sel.
- LOCKED:
  - child_ready[gnt]=!fifo_full. All other ready bits are 0, regardless of their valid signals.
  - Transfer with last=1: go to IDLE, rr_ptr<=gnt.
  - busy=1 in this state.
- FIFO: 2 entries of {id, last, data}.
  - Push on a child transfer, pop on a parent transfer. Simultaneous push and pop leaves count unchanged.
  - parent_* outputs come from the head entry; parent_valid = (count!=0).
  - A beat accepted at edge t is visible on parent_valid after edge t (1-cycle latency when the FIFO is empty).
  - Sustained throughput is 1 beat/cycle when parent_ready is held high.
- Backpressure: while parent_ready=0 with count=2, all child_ready=0 and parent outputs are held stable.
- Round-robin fairness: with all children continuously valid and single-beat packets, grants go 0,1,2,3,4,0,...
- Assertions: at most one child_ready bit high; no push when full; no pop when empty.

Decomposition:
- Package fanin_pkg holds:
  - localparam defaults (NUM_CHILD, DATA_W, ID_W)
  - typedef enum logic {IDLE, LOCKED} arb_state_e
  - typedef struct packed {id, last, data} fanin_beat_t
- One sub-module: fanin_skid_fifo, the 2-entry FIFO of fanin_beat_t with push/pop/full/empty.
- Arbiter logic (round-robin select, lock state machine) stays in child_fanin_arbiter.

Test Plan:
1. Reset, then child 2 sends a single beat 0xABCD with last=1 while parent_ready=1: transfer in the same cycle; next cycle parent_valid=1, parent_data=0xABCD, parent_id=2, parent_last=1.
2. All 5 children hold single-beat packets with data 0x1000+i and parent_ready=1: output ids 0,1,2,3,4,0, one per cycle, no bubbles after the first.
3. Child 1 sends a 4-beat packet while child 0 is also valid: ids on the output are 1,1,1,1 then 0. child_ready[0]=0 throughout the lock and busy=1 for those beats.
4. parent_ready=0 for 6 cycles with child 3 streaming: exactly 2 beats are accepted, then child_ready=0 and parent_data is held. Releasing parent_ready drains in order with no loss or duplication.
5. Assert rst after beat 2 of a 4-beat packet from child 4: outputs are 0 immediately (async), FIFO is empty, and after release child 0 is granted first when children 0 and 4 are both valid.
6. Random valid/last/parent_ready, 10k cycles, scoreboard per child: per-child order is preserved, packets are never interleaved on the output, and the one-hot ready assertion never fires.
